// File: rtl/uart_led_cmd.sv
// uart_led_cmd: UART command decoder that sets the 4-bit brightness of three
// PWM-driven LEDs. Commands: R/G/B followed by one hex digit sets a level,
// X clears all levels.
// Optional feature: define UART_LED_CMD_ECHO_EN to echo '!' or '?' back over
// the UART after every completed command. Without it, nothing is transmitted.
module uart_led_cmd #(
    parameter int unsigned PWM_DIV = 750
) (
    input  logic        hw_clk,
    input  logic        resetn,
    input  logic [31:0] reg_dat_do,
    output logic        reg_dat_re,
    output logic        reg_dat_we,
    output logic [31:0] reg_dat_di,
    input  logic        reg_dat_wait,
    output logic        pwm_red,
    output logic        pwm_green,
    output logic        pwm_blue
);

    localparam int unsigned   PW         = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV - 1);

`ifdef UART_LED_CMD_ECHO_EN
    typedef enum logic [1:0] {POLL, ARG, ECHO} state_t;
    localparam state_t DONE = ECHO;
`else
    typedef enum logic {POLL, ARG} state_t;
    localparam state_t DONE = POLL;
`endif

    state_t          state_q, state_d;
    logic            re_q, re_d;
    logic [7:0]      byte_q;
    logic [1:0]      chan_q, chan_d;
    logic [7:0]      ack_q, ack_d;
    logic [2:0][3:0] pend_q, pend_d;
    logic [2:0][3:0] act_q;
    logic [PW-1:0]   presc_q;
    logic [3:0]      step_q;
    logic [4:0]      hex;

    // {valid, value} for an ASCII hex digit, case-insensitive
    function automatic logic [4:0] hex_dec(input logic [7:0] b);
        if (b >= "0" && b <= "9") return {1'b1, 4'(b - "0")};
        if (b >= "A" && b <= "F") return {1'b1, 4'(b - "A" + 8'd10)};
        if (b >= "a" && b <= "f") return {1'b1, 4'(b - "a" + 8'd10)};
        return 5'b0;
    endfunction

    // Next-state: a byte is captured with the re pulse and decoded in the
    // following cycle, so re and the echo strobe can never coincide.
    always_comb begin
        state_d = state_q;
        re_d    = 1'b0;
        chan_d  = chan_q;
        ack_d   = ack_q;
        pend_d  = pend_q;
        hex     = hex_dec(byte_q);
`ifdef UART_LED_CMD_ECHO_EN
        if (state_q == ECHO) begin
            if (!reg_dat_wait) state_d = POLL;
        end else
`endif
        if (re_q) begin
            case (state_q)
                POLL: begin
                    if (byte_q == "R") begin
                        chan_d  = 2'd0;
                        state_d = ARG;
                    end else if (byte_q == "G") begin
                        chan_d  = 2'd1;
                        state_d = ARG;
                    end else if (byte_q == "B") begin
                        chan_d  = 2'd2;
                        state_d = ARG;
                    end else if (byte_q == "X") begin
                        pend_d  = '0;
                        ack_d   = "!";
                        state_d = DONE;
                    end else begin
                        ack_d   = "?";
                        state_d = DONE;
                    end
                end
                ARG: begin
                    if (hex[4]) begin
                        case (chan_q)
                            2'd0:    pend_d[0] = hex[3:0];
                            2'd1:    pend_d[1] = hex[3:0];
                            default: pend_d[2] = hex[3:0];
                        endcase
                        ack_d = "!";
                    end else begin
                        ack_d = "?";
                    end
                    state_d = DONE;
                end
                default: ;
            endcase
        end else if (reg_dat_do != '1) begin
            re_d = 1'b1;
        end
    end

    // Command-path registers
    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= POLL;
            re_q    <= 1'b0;
            byte_q  <= '0;
            chan_q  <= '0;
            ack_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            chan_q  <= chan_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            if (re_d) byte_q <= reg_dat_do[7:0];
        end
    end

    // PWM timebase; active levels only change at the period boundary
    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            presc_q   <= '0;
            step_q    <= '0;
            act_q     <= '0;
            pwm_red   <= 1'b0;
            pwm_green <= 1'b0;
            pwm_blue  <= 1'b0;
        end else begin
            pwm_red   <= act_q[0] > step_q;
            pwm_green <= act_q[1] > step_q;
            pwm_blue  <= act_q[2] > step_q;
            if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                step_q  <= step_q + 4'd1;
                if (step_q == 4'd15) act_q <= pend_q;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    assign reg_dat_re = re_q;

`ifdef UART_LED_CMD_ECHO_EN
    assign reg_dat_we = (state_q == ECHO);
    assign reg_dat_di = (state_q == ECHO) ? {24'b0, ack_q} : '0;
`else
    assign reg_dat_we = 1'b0;
    assign reg_dat_di = '0;
    logic [8:0] unused_no_echo;
    assign unused_no_echo = {ack_q, reg_dat_wait};
`endif

endmodule

// File: tb/tb_uart_led_cmd.sv
// Testbench for uart_led_cmd: random command bytes from a UART model, a
// command-level reference model, and a scoreboard checking per-period PWM
// duty and (when UART_LED_CMD_ECHO_EN is defined) the echoed ack bytes.
module tb_uart_led_cmd;

    localparam int unsigned DIV    = 4;
    localparam int          PERIOD = 16 * DIV;

    typedef struct {
        int r;
        int g;
        int b;
    } duty_t;

    logic        hw_clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] reg_dat_do = '1;
    logic        reg_dat_re;
    logic        reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        reg_dat_wait = 1'b0;
    logic        pwm_red, pwm_green, pwm_blue;

    uart_led_cmd #(.PWM_DIV(DIV)) dut (
        .hw_clk      (hw_clk),
        .resetn      (resetn),
        .reg_dat_do  (reg_dat_do),
        .reg_dat_re  (reg_dat_re),
        .reg_dat_we  (reg_dat_we),
        .reg_dat_di  (reg_dat_di),
        .reg_dat_wait(reg_dat_wait),
        .pwm_red     (pwm_red),
        .pwm_green   (pwm_green),
        .pwm_blue    (pwm_blue)
    );

    always #5 hw_clk = ~hw_clk;

    int checks = 0;
    int errors = 0;

    // UART receive side and reference model state
    logic [7:0] uq[$];
    logic [7:0] ack_exp[$];
    duty_t      duty_exp[$];
    int         pend[3] = '{0, 0, 0};
    int         arg_ch  = -1;
    int         n       = 0;
    int         gap     = 0;
    int         hold    = 0;
    int         spurious_re = 0;
    logic [7:0] alpha[16] = '{"R", "G", "B", "X", "R", "G", "B", "0",
                              "3", "8", "F", "f", "a", "9", "z", "Q"};

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b - "0");
        if (b >= "A" && b <= "F") return int'(b - "A") + 10;
        if (b >= "a" && b <= "f") return int'(b - "a") + 10;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] ack;
        logic       done;
        done = 1'b1;
        ack  = "?";
        if (arg_ch >= 0) begin
            if (hexval(b) >= 0) begin
                pend[arg_ch] = hexval(b);
                ack = "!";
            end
            arg_ch = -1;
        end else if (b == "R") begin
            arg_ch = 0; done = 1'b0;
        end else if (b == "G") begin
            arg_ch = 1; done = 1'b0;
        end else if (b == "B") begin
            arg_ch = 2; done = 1'b0;
        end else if (b == "X") begin
            pend = '{0, 0, 0};
            ack  = "!";
        end
`ifdef UART_LED_CMD_ECHO_EN
        if (done) ack_exp.push_back(ack);
`else
        if (done && ack == 8'h00) $display("unexpected ack");
`endif
    endtask

    // One clock of stimulus, advanced at the falling edge. A level change
    // from a byte consumed at edge k+1 lands in the period whose boundary
    // edge is later than k+1, hence the snapshot precedes the pop.
    task automatic step(input bit allow_new);
        duty_t d;
        @(negedge hw_clk);
        n++;
        if ((n + 1) % PERIOD == 0) begin
            d.r = DIV * pend[0]; d.g = DIV * pend[1]; d.b = DIV * pend[2];
            duty_exp.push_back(d);
        end
        if (reg_dat_re) begin
            if (uq.size() == 0) spurious_re++;
            else model_byte(uq.pop_front());
        end
        if (allow_new && uq.size() == 0) begin
            if (gap == 0) begin
                uq.push_back(alpha[$urandom_range(0, 15)]);
                gap = $urandom_range(0, 30);
            end else gap--;
        end
        reg_dat_do = (uq.size() != 0) ? {24'b0, uq[0]} : '1;
        if (hold > 0) begin
            hold--;
            reg_dat_wait = 1'b1;
        end else if (allow_new && $urandom_range(0, 15) == 0) begin
            hold = 19;
            reg_dat_wait = 1'b1;
        end else begin
            reg_dat_wait = allow_new && ($urandom_range(0, 3) == 0);
        end
    endtask

    // Monitor: per-period duty scoreboard, echo scoreboard, protocol rules
    logic        mon_on = 1'b0;
    int          mon_n = 0, cr = 0, cg = 0, cb = 0;
    logic        prev_re = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_di = '0;
    logic        wait_at_edge = 1'b0;
    int          dbl_re = 0, re_we = 0, we_bad = 0;

    always @(posedge hw_clk) wait_at_edge <= reg_dat_wait;

    always @(negedge hw_clk) begin
        if (mon_on) begin
            duty_t e;
            mon_n++;
            cr += int'(pwm_red); cg += int'(pwm_green); cb += int'(pwm_blue);
            if (mon_n % PERIOD == 0) begin
                checks++;
                if (duty_exp.size() == 0) begin
                    errors++;
                    $display("FAIL duty_queue period=%0d got=empty required=entry", mon_n / PERIOD);
                end else begin
                    e = duty_exp.pop_front();
                    if (cr != e.r || cg != e.g || cb != e.b) begin
                        errors++;
                        $display("FAIL duty period=%0d got r=%0d g=%0d b=%0d required r=%0d g=%0d b=%0d",
                                 mon_n / PERIOD, cr, cg, cb, e.r, e.g, e.b);
                    end
                end
                cr = 0; cg = 0; cb = 0;
            end
            if (reg_dat_re && prev_re) dbl_re++;
            if (reg_dat_re && reg_dat_we) re_we++;
`ifdef UART_LED_CMD_ECHO_EN
            if (prev_we && !wait_at_edge) begin
                checks++;
                if (ack_exp.size() == 0) begin
                    errors++;
                    $display("FAIL echo got=%02h required=none", prev_di[7:0]);
                end else begin
                    logic [31:0] want;
                    want = {24'b0, ack_exp.pop_front()};
                    if (prev_di != want) begin
                        errors++;
                        $display("FAIL echo got=%08h required=%08h", prev_di, want);
                    end
                end
                if (reg_dat_we) we_bad++;
            end else if (prev_we && (!reg_dat_we || reg_dat_di != prev_di)) begin
                we_bad++;
            end
`else
            if (reg_dat_we || reg_dat_di != 32'd0) we_bad++;
`endif
            prev_re = reg_dat_re;
            prev_we = reg_dat_we;
            prev_di = reg_dat_di;
        end
    end

    task automatic check_zero(input string name, input int got);
        checks++;
        if (got != 0) begin
            errors++;
            $display("FAIL %s got=%0d required=0", name, got);
        end
    endtask

    initial begin
        duty_t d0;
        #22;
        check_zero("reset_outputs", int'({reg_dat_re, reg_dat_we, pwm_red, pwm_green, pwm_blue})
                                    + int'(reg_dat_di != 32'd0));
        d0.r = 0; d0.g = 0; d0.b = 0;
        duty_exp.push_back(d0);
        #80;
        resetn = 1'b1;
        mon_on = 1'b1;

        repeat (2400) step(1'b1);
        repeat (200) step(1'b0);
        check_zero("rx_backlog", uq.size());
        check_zero("echo_backlog", ack_exp.size());

        // Full brightness on every channel, long enough for whole periods
        uq.push_back("R"); uq.push_back("F");
        uq.push_back("G"); uq.push_back("F");
        uq.push_back("B"); uq.push_back("F");
        repeat (300) step(1'b0);

        // Reset during a pending echo
        uq.push_back("Q");
`ifdef UART_LED_CMD_ECHO_EN
        for (int i = 0; i < 50 && !reg_dat_we; i++) step(1'b0);
        checks++;
        if (!reg_dat_we) begin
            errors++;
            $display("FAIL echo_before_reset got=0 required=1");
        end
`else
        repeat (5) step(1'b0);
`endif
        #1 mon_on = 1'b0;
        #1 resetn = 1'b0;
        #1;
        check_zero("async_reset_outputs", int'({reg_dat_re, reg_dat_we, pwm_red, pwm_green, pwm_blue})
                                          + int'(reg_dat_di != 32'd0));

        check_zero("double_re", dbl_re);
        check_zero("re_with_we", re_we);
        check_zero("we_protocol", we_bad);
        check_zero("spurious_re", spurious_re);

        // Polling resumes on the first edge after reset release
        repeat (3) @(negedge hw_clk);
        uq.delete();
        uq.push_back("G");
        reg_dat_do = {24'b0, uq[0]};
        #2 resetn = 1'b1;
        @(negedge hw_clk);
        checks++;
        if (reg_dat_re !== 1'b1) begin
            errors++;
            $display("FAIL resume_re got=%b required=1", reg_dat_re);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
